// File: rtl/adda_sequencer.sv
// Clock/phase sequencer for an 8-bit parallel ADC feeding an 8-bit DAC.
// Generates ADCLK/DACLK, flushes ADC pipeline latency, and drives the DAC per MODE.
module adda_sequencer #(
  parameter int unsigned DIV         = 2,
  parameter int unsigned ADC_LATENCY = 3
) (
  input  logic       GLOBAL_CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       STOP,
  input  logic [1:0] MODE,
  input  logic [7:0] ADIN_DATA,
  output logic       ADCLK,
  output logic       DACLK,
  output logic [7:0] DAOUT_DATA,
  output logic [7:0] SAMPLE_DATA,
  output logic       SAMPLE_VALID,
  output logic       BUSY
);

  localparam int unsigned PhaseW = $clog2(2 * DIV);
  localparam logic [PhaseW-1:0] PhaseCap  = PhaseW'(DIV - 1);
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(2 * DIV - 1);
  localparam logic [7:0] MidScale = 8'h80;

  typedef enum logic [1:0] {StIdle, StFlush, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic              adclk_q, adclk_d;
  logic [3:0]        flush_q, flush_d;
  logic [7:0]        ramp_q, ramp_d;
  logic [7:0]        daout_q, daout_d;
  logic [7:0]        sample_q, sample_d;
  logic              valid_q, valid_d;
  logic              cap_edge, wrap_edge;

  // Phase value held before the edge that drops ADCLK / the edge that wraps to 0.
  assign cap_edge  = (phase_q == PhaseCap);
  assign wrap_edge = (phase_q == PhaseLast);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    adclk_d  = adclk_q;
    flush_d  = flush_q;
    ramp_d   = ramp_q;
    daout_d  = daout_q;
    sample_d = sample_q;
    valid_d  = 1'b0;

    if (state_q != StIdle) begin
      phase_d = wrap_edge ? '0 : phase_q + PhaseW'(1);
      if (cap_edge) begin
        adclk_d = 1'b0;
      end else if (wrap_edge) begin
        // No new rising edge once stopping or draining.
        adclk_d = !STOP && (state_q == StFlush || state_q == StRun);
      end
    end

    unique case (state_q)
      StIdle: begin
        adclk_d = 1'b0;
        phase_d = '0;
        daout_d = MidScale;
        if (START && !STOP) begin
          adclk_d = 1'b1;
          if (ADC_LATENCY == 0) begin
            state_d = StRun;
            ramp_d  = 8'h00;
          end else begin
            state_d = StFlush;
            flush_d = 4'(ADC_LATENCY);
          end
        end
      end
      StFlush: begin
        if (STOP) begin
          state_d = StDrain;
        end else if (cap_edge) begin
          flush_d = flush_q - 4'd1;
          if (flush_q == 4'd1) begin
            state_d = StRun;
            ramp_d  = 8'h00;
          end
        end
      end
      StRun: begin
        if (STOP) begin
          state_d = StDrain;
        end else if (cap_edge) begin
          sample_d = ADIN_DATA;
          valid_d  = 1'b1;
          unique case (MODE)
            2'b00: daout_d = ADIN_DATA;
            2'b01: daout_d = ~ADIN_DATA;
            2'b10: daout_d = daout_q;
            2'b11: begin
              daout_d = ramp_q;
              ramp_d  = ramp_q + 8'd1;
            end
            default: daout_d = daout_q;
          endcase
        end
      end
      StDrain: begin
        if (wrap_edge) begin
          state_d = StIdle;
          daout_d = MidScale;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge GLOBAL_CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      adclk_q  <= 1'b0;
      flush_q  <= 4'd0;
      ramp_q   <= 8'h00;
      daout_q  <= MidScale;
      sample_q <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      adclk_q  <= adclk_d;
      flush_q  <= flush_d;
      ramp_q   <= ramp_d;
      daout_q  <= daout_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign ADCLK        = adclk_q;
  assign DACLK        = adclk_q;
  assign DAOUT_DATA   = daout_q;
  assign SAMPLE_DATA  = sample_q;
  assign SAMPLE_VALID = valid_q;
  assign BUSY         = (state_q != StIdle);

endmodule

// File: tb/tb_adda_sequencer.sv
// Bench for adda_sequencer: scoreboard on SAMPLE_VALID plus directed clock/state checks.
module tb_adda_sequencer;

  logic       clk = 1'b0;
  logic       rst, start_a, stop_a, start_b, stop_b;
  logic [1:0] mode;
  logic [7:0] adin;

  logic       a_adclk, a_daclk, a_valid, a_busy;
  logic [7:0] a_dac, a_sdata;
  logic       b_adclk, b_daclk, b_valid, b_busy;
  logic [7:0] b_dac, b_sdata;

  always #5 clk = ~clk;

  adda_sequencer #(.DIV(2), .ADC_LATENCY(3)) dut_a (
    .GLOBAL_CLK(clk), .RESET(rst), .START(start_a), .STOP(stop_a), .MODE(mode),
    .ADIN_DATA(adin), .ADCLK(a_adclk), .DACLK(a_daclk), .DAOUT_DATA(a_dac),
    .SAMPLE_DATA(a_sdata), .SAMPLE_VALID(a_valid), .BUSY(a_busy)
  );

  adda_sequencer #(.DIV(1), .ADC_LATENCY(0)) dut_b (
    .GLOBAL_CLK(clk), .RESET(rst), .START(start_b), .STOP(stop_b), .MODE(mode),
    .ADIN_DATA(adin), .ADCLK(b_adclk), .DACLK(b_daclk), .DAOUT_DATA(b_dac),
    .SAMPLE_DATA(b_sdata), .SAMPLE_VALID(b_valid), .BUSY(b_busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] dac;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic qchk(input string name);
    @(negedge clk);
    #1;
    chk(name, q.size(), 0);
  endtask

  // Queue the expected strobe, then advance through the next capture edge of dut_a.
  task automatic cap(input logic [7:0] din, input logic [1:0] md, input logic [7:0] dac);
    exp_t e;
    adin   = din;
    mode   = md;
    e.data = din;
    e.dac  = dac;
    q.push_back(e);
    do tick(); while (n % 4 != 2);
  endtask

  // Scoreboard monitor for dut_a.
  initial begin
    forever begin
      @(negedge clk);
      if (a_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got strobe data %0h dac %0h, required none (t=%0t)",
                   a_sdata, a_dac, $time);
        end else begin
          mon_e = q.pop_front();
          chk("sample_data", a_sdata, mon_e.data);
          chk("dac_data", a_dac, mon_e.dac);
        end
      end
    end
  end

  initial begin
    int nn;
    rst = 1'b1; start_a = 1'b1; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0;
    mode = 2'b00; adin = 8'h00; n = 0;

    // Reset with START held high
    repeat (3) begin
      tick();
      chk("rst_adclk", a_adclk, 0);
      chk("rst_daclk", a_daclk, 0);
      chk("rst_dac", a_dac, 8'h80);
      chk("rst_busy", a_busy, 0);
      chk("rst_sdata", a_sdata, 8'h00);
      chk("rst_valid", a_valid, 0);
    end
    rst = 1'b0; start_a = 1'b0;
    tick();
    chk("idle_busy", a_busy, 0);

    // START+STOP together in IDLE
    start_a = 1'b1; stop_a = 1'b1;
    tick();
    start_a = 1'b0; stop_a = 1'b0;
    chk("ss_busy", a_busy, 0);
    chk("ss_adclk", a_adclk, 0);
    tick();
    chk("ss_busy2", a_busy, 0);

    // Flush latency, ADIN = capture index
    start_a = 1'b1; n = -1;
    tick();
    start_a = 1'b0;
    chk("e0_busy", a_busy, 1);
    chk("e0_adclk", a_adclk, 1);
    while (n < 22) begin
      nn   = n + 1;
      adin = (nn >= 2) ? 8'((nn - 2) / 4) : 8'h00;
      if (nn >= 14 && (nn - 2) % 4 == 0) cap(adin, 2'b00, adin);
      else tick();
      chk("fl_adclk", a_adclk, ((n % 4) < 2) ? 1 : 0);
      chk("fl_daclk", a_daclk, ((n % 4) < 2) ? 1 : 0);
      chk("fl_valid", a_valid, (n >= 14 && (n - 2) % 4 == 0) ? 1 : 0);
      if (n < 14) chk("fl_dac_mid", a_dac, 8'h80);
    end
    qchk("fl_queue");

    // Modes, then full ramp wrap
    cap(8'h3C, 2'b00, 8'h3C);
    cap(8'h3C, 2'b01, 8'hC3);
    cap(8'h3C, 2'b10, 8'hC3);
    cap(8'h3C, 2'b11, 8'h00);
    cap(8'h77, 2'b11, 8'h01);
    cap(8'h88, 2'b11, 8'h02);
    for (int i = 3; i < 256; i++) cap(8'(i), 2'b11, 8'(i));
    cap(8'hAB, 2'b11, 8'h00);
    qchk("mode_queue");

    // START during RUN must not restart the flush
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("rs_busy", a_busy, 1);
    cap(8'h5A, 2'b00, 8'h5A);
    cap(8'hA5, 2'b01, 8'h5A);
    qchk("rs_queue");

    // STOP at p=0 while ADCLK high
    while (n % 4 != 0) tick();
    stop_a = 1'b1; adin = 8'hEE;
    tick();
    stop_a = 1'b0;
    chk("st_adclk0", a_adclk, 1);
    chk("st_busy0", a_busy, 1);
    tick();
    chk("st_adclk1", a_adclk, 0);
    chk("st_valid1", a_valid, 0);
    chk("st_busy1", a_busy, 1);
    tick();
    chk("st_adclk2", a_adclk, 0);
    chk("st_busy2", a_busy, 1);
    tick();
    chk("st_busy3", a_busy, 0);
    chk("st_adclk3", a_adclk, 0);
    chk("st_dac3", a_dac, 8'h80);
    repeat (5) begin
      tick();
      chk("st_norise", a_adclk, 0);
    end

    // RESET during FLUSH
    start_a = 1'b1; n = -1;
    tick();
    start_a = 1'b0;
    tick();
    chk("rf_adclk_hi", a_adclk, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rf_busy", a_busy, 0);
    chk("rf_adclk", a_adclk, 0);
    chk("rf_daclk", a_daclk, 0);
    chk("rf_dac", a_dac, 8'h80);
    repeat (4) begin
      tick();
      chk("rf_idle_busy", a_busy, 0);
      chk("rf_idle_adclk", a_adclk, 0);
    end

    // DIV=1, ADC_LATENCY=0
    adin = 8'h5A; mode = 2'b00; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b_e0_adclk", b_adclk, 1);
    chk("b_e0_busy", b_busy, 1);
    chk("b_e0_valid", b_valid, 0);
    tick();
    chk("b_e1_adclk", b_adclk, 0);
    chk("b_e1_valid", b_valid, 1);
    chk("b_e1_sdata", b_sdata, 8'h5A);
    chk("b_e1_dac", b_dac, 8'h5A);
    adin = 8'h11;
    tick();
    chk("b_e2_adclk", b_adclk, 1);
    chk("b_e2_valid", b_valid, 0);
    tick();
    chk("b_e3_adclk", b_adclk, 0);
    chk("b_e3_valid", b_valid, 1);
    chk("b_e3_sdata", b_sdata, 8'h11);
    mode = 2'b01;
    tick();
    chk("b_e4_adclk", b_adclk, 1);
    tick();
    chk("b_e5_dac", b_dac, 8'hEE);
    stop_b = 1'b1;
    tick();
    stop_b = 1'b0;
    chk("b_st_adclk", b_adclk, 0);
    chk("b_st_busy", b_busy, 1);
    tick();
    chk("b_st_adclk2", b_adclk, 0);
    chk("b_st_valid", b_valid, 0);
    chk("b_st_busy2", b_busy, 1);
    tick();
    chk("b_st_busy3", b_busy, 0);
    chk("b_st_dac", b_dac, 8'h80);

    qchk("final_queue");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adda_sequencer.md
# adda_sequencer

Sequencer for the 8-bit parallel ADC → fabric → 8-bit DAC datapath on the iCE40 UltraPlus board. It generates divided ADCLK/DACLK from the 12 MHz fabric clock and captures ADC words at a fixed phase. It discards the converter's pipeline-latency samples after start-up and drives the DAC from the captured stream in one of four modes. It sits between the top-level pads and downstream processing, and replaces direct oscillator-to-pad clocking.

## Interface
- DIV, default 2: ADCLK half-period in GLOBAL_CLK cycles; legal 1..255; converter clock = GLOBAL_CLK/(2·DIV).
- ADC_LATENCY, default 3: ADC pipeline depth in conversions; this many captures are discarded after START; legal 0..15.
- GLOBAL_CLK  in  1  fabric clock (12 MHz from SB_HFOSC); the single clock domain.
- RESET  in  1  synchronous, active-high.
- START  in  1  one-cycle request to begin conversion.
- STOP  in  1  one-cycle request to end conversion.
- MODE  in  2  DAC source: 00 pass-through, 01 invert, 10 hold, 11 ramp.
- ADIN_DATA  in  8  ADC output bus.
- ADCLK  out  1  ADC conversion clock, registered.
- DACLK  out  1  DAC latch clock, registered, identical to ADCLK.
- DAOUT_DATA  out  8  DAC input bus, registered.
- SAMPLE_DATA  out  8  last valid captured ADC word.
- SAMPLE_VALID  out  1  one-cycle strobe, qualifies SAMPLE_DATA.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, FLUSH, RUN, DRAIN.
- Phase counter p runs 0..2·DIV−1 and wraps. It counts only outside IDLE.
- ADCLK/DACLK:
  - Set on the edge where p wraps to 0, or on entry to FLUSH.
  - Cleared on the edge where p reaches DIV. This is the capture edge.
- Capture edge: ADIN_DATA is registered on the same GLOBAL_CLK edge that drops ADCLK.
- IDLE:
  - Clocks low, p=0, DAOUT_DATA=0x80 (midscale).
  - START → FLUSH, with a flush counter loaded to ADC_LATENCY. If ADC_LATENCY=0, go directly to RUN.
- FLUSH:
  - Each capture decrements the flush counter and is discarded: no SAMPLE_VALID, DAOUT_DATA stays 0x80.
  - The capture that brings the counter to 0 → RUN.
- RUN, on each capture:
  - SAMPLE_DATA ← ADIN_DATA.
  - SAMPLE_VALID pulses for 1 cycle.
  - DAOUT_DATA updates per MODE, sampled at that capture edge:
    - 00: ADIN_DATA.
    - 01: ~ADIN_DATA.
    - 10: unchanged.
    - 11: ramp counter value, which then increments mod 256.
- Ramp counter clears to 0x00 on entry to RUN.
- STOP in FLUSH or RUN → DRAIN.
  - No further ADCLK rising edge.
  - A currently-high ADCLK still falls at p=DIV, so the minimum high time is preserved. That capture is discarded.
  - At p=2·DIV−1 → IDLE, DAOUT_DATA ← 0x80.
- Simultaneous START and STOP: STOP wins.
  - In IDLE: stay IDLE.
  - In FLUSH or RUN: → DRAIN.
- START outside IDLE is ignored. STOP in IDLE or DRAIN is ignored.
- MODE changes mid-stream take effect at the next capture edge; no glitch on DAOUT_DATA.

## Timing
- Reset values:
  - State IDLE, p=0.
  - ADCLK=0, DACLK=0, DAOUT_DATA=0x80.
  - SAMPLE_DATA=0x00, SAMPLE_VALID=0, BUSY=0.
  - Flush and ramp counters 0.
- RESET mid-operation forces all of the above on the next edge, regardless of state; clocks stop low immediately.
- Let START be sampled at edge E0:
  - BUSY=1 and ADCLK=1 after E0.
  - Captures occur at E0+DIV+k·2·DIV.
  - The first valid capture is k=ADC_LATENCY.
- SAMPLE_VALID and the new DAOUT_DATA are visible in the cycle following the capture edge.
- The DAC latches that value on the next DACLK rise, DIV cycles later. Input-to-DAC latency is 1 converter period plus ADC_LATENCY.
- DIV=1: ADCLK toggles every cycle (6 MHz); every second edge is a capture.
- BUSY deasserts in the cycle after DRAIN exits.

## Test plan
- Reset/idle:
  - Stimulus: assert RESET for 3 cycles with START held high.
  - Response: ADCLK=DACLK=0, DAOUT_DATA=0x80, BUSY=0, SAMPLE_VALID never high.
- Flush latency (DIV=2, ADC_LATENCY=3, MODE=00):
  - Stimulus: START at E0, ADIN_DATA = capture index.
  - Response: captures at E2, E6, E10 discarded; first SAMPLE_VALID after E14 with SAMPLE_DATA=3 and DAOUT_DATA=3.
  - Response: SAMPLE_VALID period is 4 cycles and the ADCLK duty cycle is 2/2.
- Modes:
  - Stimulus: in RUN with ADIN_DATA=0x3C, step MODE 00→01→10→11 on consecutive captures.
  - Response: DAOUT_DATA = 0x3C, 0xC3, 0xC3, 0x00.
  - Response: further captures in ramp mode give 0x01, 0x02; after 256 captures the ramp wraps 0xFF→0x00.
- STOP mid-high:
  - Stimulus: STOP at p=0 in RUN.
  - Response: ADCLK falls at p=DIV, no SAMPLE_VALID, no further rising edge, IDLE at p=2·DIV−1, DAOUT_DATA=0x80.
- Simultaneous events:
  - Stimulus: START+STOP in IDLE.
  - Response: stays IDLE.
  - Stimulus: START during RUN.
  - Response: no restart of flush.
  - Stimulus: RESET during FLUSH.
  - Response: IDLE next cycle, clocks low.
- Edge parameters:
  - Stimulus: DIV=1 and ADC_LATENCY=0, START.
  - Response: ADCLK toggles every cycle; first SAMPLE_VALID after E1.
